// File: rtl/turn_controller.sv
// turn_controller: referee for a two-player tic-tac-toe game fed by X and O move request streams.
// Latency: a legal move lands on the board at its transfer edge; turn toggle or game_over one edge later.
// Backpressure: only the player to move sees ready, and never while start is high; the other stream is ignored.
// Optional feature: define TTT_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle WAIT_MOVE cycles.
module turn_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        x_valid,
  input  logic [3:0]  x_cell,
  output logic        x_ready,
  input  logic        o_valid,
  input  logic [3:0]  o_cell,
  output logic        o_ready,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        move_err,
  output logic        timeout,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_MOVE = 2'd1,
    ST_CHECK     = 2'd2,
    ST_OVER      = 2'd3
  } state_t;

  localparam logic [1:0] PL_NONE   = 2'd0;
  localparam logic [1:0] PL_X      = 2'd1;
  localparam logic [1:0] PL_O      = 2'd2;
  localparam logic [1:0] CELL_BAD  = 2'd3;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [3:0]  move_cnt_q, move_cnt_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic        move_err_q, move_err_d;

  logic        mover_ready;
  logic        act_valid;
  logic [3:0]  act_cell;
  logic [1:0]  cell_code;
  logic        xfer;
  logic        legal;
  logic        illegal;
  logic        line_won;
  logic        board_full;
  logic [1:0]  other_player;

  // True when player p holds any of the eight winning lines on board b.
  function automatic logic owns_line(input logic [17:0] b, input logic [1:0] p);
    logic [8:0] m;
    for (int k = 0; k < 9; k++) begin
      m[k] = (b[2*k +: 2] == p);
    end
    owns_line = (m[0] & m[1] & m[2]) |
                (m[3] & m[4] & m[5]) |
                (m[6] & m[7] & m[8]) |
                (m[0] & m[3] & m[6]) |
                (m[1] & m[4] & m[7]) |
                (m[2] & m[5] & m[8]) |
                (m[0] & m[4] & m[8]) |
                (m[2] & m[4] & m[6]);
  endfunction

`ifdef TTT_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1 before it wraps back to zero.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
  logic          expire;
`endif

  // Ready is combinational so a mover can transfer in the first WAIT_MOVE cycle.
  always_comb begin
    mover_ready = (state_q == ST_WAIT_MOVE) && !start;
    x_ready     = mover_ready && (turn_q == PL_X);
    o_ready     = mover_ready && (turn_q == PL_O);
  end

  // Select the request of whoever is to move; the other stream never reaches the datapath.
  always_comb begin
    act_valid = 1'b0;
    act_cell  = 4'd0;
    if (turn_q == PL_X) begin
      act_valid = x_valid;
      act_cell  = x_cell;
    end else if (turn_q == PL_O) begin
      act_valid = o_valid;
      act_cell  = o_cell;
    end
  end

  // Look up the requested cell; indices past 8 read as occupied so they fall out as illegal.
  always_comb begin
    cell_code = CELL_BAD;
    for (int k = 0; k < 9; k++) begin
      if (act_cell == 4'(k)) begin
        cell_code = board_q[2*k +: 2];
      end
    end
  end

  // Transfer qualification and end-of-game conditions evaluated on the registered board.
  always_comb begin
    xfer         = act_valid && mover_ready;
    legal        = xfer && (cell_code == PL_NONE);
    illegal      = xfer && (cell_code != PL_NONE);
    line_won     = owns_line(board_q, turn_q);
    board_full   = (move_cnt_q == MAX_MOVES);
    other_player = (turn_q == PL_X) ? PL_O : PL_X;
  end

`ifdef TTT_TIMEOUT_EN
  // A turn expires only on a cycle with no transfer at all; a legal move on the last cycle wins.
  always_comb begin
    expire = (state_q == ST_WAIT_MOVE) && !start && !xfer && (tmo_cnt_q == TMO_LAST);
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start restarts from any state; CHECK is always a single cycle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_WAIT_MOVE;
    end else begin
      case (state_q)
        ST_WAIT_MOVE: begin
          if (legal) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (line_won || board_full) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_WAIT_MOVE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output/datapath next values: board write, move counting, judging and pulses.
  always_comb begin
    board_d     = board_q;
    turn_d      = turn_q;
    move_cnt_d  = move_cnt_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    move_err_d  = 1'b0;
`ifdef TTT_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = 1'b0;
`endif
    if (start) begin
      board_d     = '0;
      turn_d      = PL_X;
      move_cnt_d  = '0;
      winner_d    = PL_NONE;
      game_over_d = 1'b0;
`ifdef TTT_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_WAIT_MOVE: begin
          if (legal) begin
            for (int k = 0; k < 9; k++) begin
              if (act_cell == 4'(k)) begin
                board_d[2*k +: 2] = turn_q;
              end
            end
            if (move_cnt_q < MAX_MOVES) begin
              move_cnt_d = move_cnt_q + 4'd1;
            end
          end else if (illegal) begin
            move_err_d = 1'b1;
          end
`ifdef TTT_TIMEOUT_EN
          if (xfer) begin
            tmo_cnt_d = '0;
          end else if (expire) begin
            tmo_cnt_d = '0;
            turn_d    = other_player;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
`endif
        end
        ST_CHECK: begin
          if (line_won) begin
            winner_d    = turn_q;
            game_over_d = 1'b1;
            turn_d      = PL_NONE;
          end else if (board_full) begin
            winner_d    = PL_NONE;
            game_over_d = 1'b1;
            turn_d      = PL_NONE;
          end else begin
            turn_d = other_player;
          end
`ifdef TTT_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
        default: begin
          // IDLE and OVER hold everything until the next start.
        end
      endcase
    end
  end

  // Registered game state and output pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board_q     <= '0;
      turn_q      <= PL_NONE;
      move_cnt_q  <= '0;
      winner_q    <= PL_NONE;
      game_over_q <= 1'b0;
      move_err_q  <= 1'b0;
    end else begin
      board_q     <= board_d;
      turn_q      <= turn_d;
      move_cnt_q  <= move_cnt_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      move_err_q  <= move_err_d;
    end
  end

`ifdef TTT_TIMEOUT_EN
  // Turn-forfeit timer and its one-cycle pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign board     = board_q;
  assign turn      = turn_q;
  assign move_err  = move_err_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized and directed stimulus for turn_controller against a cell-array game model.
// Expected outputs per cycle are queued by the driver and compared by an independent negedge monitor.
module tb_turn_controller;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        x_valid = 1'b0;
  logic [3:0]  x_cell = 4'd0;
  logic        o_valid = 1'b0;
  logic [3:0]  o_cell = 4'd0;
  logic        x_ready, o_ready, move_err, timeout, game_over;
  logic [17:0] board;
  logic [1:0]  turn, winner;

  always #5 clock = ~clock;

  turn_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .x_valid(x_valid), .x_cell(x_cell), .x_ready(x_ready),
    .o_valid(o_valid), .o_cell(o_cell), .o_ready(o_ready),
    .board(board), .turn(turn), .move_err(move_err), .timeout(timeout),
    .game_over(game_over), .winner(winner)
  );

  typedef struct {
    bit          xr;
    bit          orr;
    logic [17:0] board;
    logic [1:0]  turn;
    bit          err;
    bit          tmo;
    bit          go;
    logic [1:0]  win;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: plain cell array plus a few flags describing what the referee is doing.
  int cells[9];
  int to_move, moves, winner_m, idle_cycles;
  bit playing, judging, over_m, err_m, tmo_m;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) cells[k] = 0;
    to_move = 0; moves = 0; winner_m = 0; idle_cycles = 0;
    playing = 0; judging = 0; over_m = 0; err_m = 0; tmo_m = 0;
  endfunction

  function automatic bit owns(int p);
    for (int l = 0; l < 8; l++)
      if (cells[lines[l][0]] == p && cells[lines[l][1]] == p && cells[lines[l][2]] == p) return 1;
    return 0;
  endfunction

  function automatic void model_step(bit s, bit xv, int xc, bit ov, int oc);
    bit v;
    int c;
    err_m = 0;
    tmo_m = 0;
    if (s) begin
      for (int k = 0; k < 9; k++) cells[k] = 0;
      moves = 0; winner_m = 0; over_m = 0; to_move = 1;
      playing = 1; judging = 0; idle_cycles = 0;
    end else if (judging) begin
      judging = 0;
      idle_cycles = 0;
      if (owns(to_move)) begin
        over_m = 1; winner_m = to_move; to_move = 0;
      end else if (moves == 9) begin
        over_m = 1; winner_m = 0; to_move = 0;
      end else begin
        to_move = 3 - to_move; playing = 1;
      end
    end else if (playing) begin
      v = (to_move == 1) ? xv : ov;
      c = (to_move == 1) ? xc : oc;
      if (v) begin
        idle_cycles = 0;
        if (c < 9 && cells[c] == 0) begin
          cells[c] = to_move; moves++; playing = 0; judging = 1;
        end else begin
          err_m = 1;
        end
      end else begin
`ifdef TTT_TIMEOUT_EN
        idle_cycles++;
        if (idle_cycles == T) begin
          to_move = 3 - to_move; tmo_m = 1; idle_cycles = 0;
        end
`endif
      end
    end
  endfunction

  function automatic exp_t snapshot(bit s);
    exp_t e;
    e.xr  = playing && to_move == 1 && !s;
    e.orr = playing && to_move == 2 && !s;
    e.board = '0;
    for (int k = 0; k < 9; k++) e.board[2*k +: 2] = 2'(cells[k]);
    e.turn = 2'(to_move);
    e.err  = err_m;
    e.tmo  = tmo_m;
    e.go   = over_m;
    e.win  = 2'(winner_m);
    return e;
  endfunction

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit s, input bit xv, input int xc, input bit ov, input int oc);
    start = s; x_valid = xv; x_cell = 4'(xc); o_valid = ov; o_cell = 4'(oc);
    sb.push_back(snapshot(s));
    @(posedge clock);
    model_step(s, xv, xc, ov, oc);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic move(input int p, input int c);
    if (p == 1) cyc(0, 1, c, 0, 0);
    else        cyc(0, 0, 0, 1, c);
  endtask

  task automatic play(input int p, input int c);
    move(p, c);
    idle(1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    reset_n = 0; start = 0; x_valid = 0; o_valid = 0;
    model_reset();
    #1;
    chk("async_board", board, 0);
    chk("async_turn", turn, 0);
    chk("async_game_over", game_over, 0);
    chk("async_winner", winner, 0);
    chk("async_move_err", move_err, 0);
    chk("async_timeout", timeout, 0);
    sb.push_back(snapshot(0));
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  function automatic int rcell();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
  endfunction

  // Monitor: compares every queued expectation against the DUT away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("x_ready", x_ready, e.xr);
      chk("o_ready", o_ready, e.orr);
      chk("board", board, e.board);
      chk("turn", turn, e.turn);
      chk("move_err", move_err, e.err);
      chk("timeout", timeout, e.tmo);
      chk("game_over", game_over, e.go);
      chk("winner", winner, e.win);
    end
  end

  initial begin
    int r;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();
    idle(3);

    // X takes the top row while O holds cells 3 and 4.
    cyc(1, 0, 0, 0, 0);
    chk("start_turn", turn, 1);
    play(1, 0); play(2, 3); play(1, 1); play(2, 4);
    move(1, 2);
    chk("lat_board", board, 18'h00295);
    chk("lat_game_over", game_over, 0);
    idle(1);
    chk("row_game_over", game_over, 1);
    chk("row_winner", winner, 1);
    chk("row_board", board, 18'h00295);
    chk("row_turn", turn, 0);
    move(1, 5);
    chk("over_hold_board", board, 18'h00295);

    // Full board, no line: draw.
    cyc(1, 0, 0, 0, 0);
    play(1, 4); play(2, 0); play(1, 2); play(2, 6); play(1, 3);
    play(2, 5); play(1, 1); play(2, 7);
    move(1, 8);
    chk("draw_game_over_early", game_over, 0);
    idle(1);
    chk("draw_game_over", game_over, 1);
    chk("draw_winner", winner, 0);
    chk("draw_board", board, 18'h1A956);

    // Occupied and off-board requests are rejected with separate pulses.
    cyc(1, 0, 0, 0, 0);
    play(1, 4);
    move(2, 4);
    chk("occupied_err", move_err, 1);
    idle(1);
    chk("err_one_cycle", move_err, 0);
    move(2, 9);
    chk("offboard_err", move_err, 1);
    chk("err_turn", turn, 2);
    chk("err_board", board, 18'h00100);

    // Out-of-turn request is ignored silently.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("oot_board", board, 0);
    chk("oot_err", move_err, 0);
    chk("oot_turn", turn, 1);

    // start wins over a simultaneous legal move.
    play(1, 0); play(2, 3);
    cyc(1, 1, 5, 0, 0);
    chk("restart_board", board, 0);
    chk("restart_turn", turn, 1);
    chk("restart_err", move_err, 0);

`ifdef TTT_TIMEOUT_EN
    // X idles through a whole turn window, then reset lands mid-count for O.
    cyc(1, 0, 0, 0, 0);
    idle(T - 1);
    chk("tmo_early", timeout, 0);
    idle(1);
    chk("tmo_pulse", timeout, 1);
    chk("tmo_turn", turn, 2);
    chk("tmo_board", board, 0);
    idle(5);
    do_reset();
`endif

    // Randomized play with occasional restarts and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) do_reset();
      else if (r < 25) cyc(1, $urandom_range(0, 1) == 1, rcell(), $urandom_range(0, 1) == 1, rcell());
      else cyc(0, $urandom_range(0, 2) == 0, rcell(), $urandom_range(0, 2) == 0, rcell());
    end
    idle(2);

    repeat (3) @(negedge clock);
    #1;
    chk("queue_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
